// File: rtl/serial_multiply_test1_pkg.sv
// Shared constants, mode encoding and FSM state type for the serial multiply test block.
package serial_multiply_test1_pkg;

    localparam int unsigned WIDTH  = 4;
    localparam int unsigned TRUNC  = 2;
    localparam int unsigned PROD_W = 2 * WIDTH;
    localparam int unsigned OUT3_W = PROD_W - TRUNC;
    localparam int unsigned STEP_W = $clog2(WIDTH);

    localparam logic [1:0] MODE_UNSIGNED = 2'd0;
    localparam logic [1:0] MODE_SIGNED   = 2'd1;
    localparam logic [1:0] MODE_TRUNC    = 2'd2;
    localparam logic [1:0] MODE_RSVD     = 2'd3;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    // Widen an operand to product width, sign- or zero-extending.
    function automatic logic [PROD_W-1:0] extend_operand(input logic [WIDTH-1:0] x,
                                                         input logic             sgn);
        logic [PROD_W-1:0] r;
        if (sgn) begin
            r = {{(PROD_W-WIDTH){x[WIDTH-1]}}, x};
        end else begin
            r = {{(PROD_W-WIDTH){1'b0}}, x};
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_multiply_test1_mult_core.sv
// Shift-add multiplier: one multiplier bit per clock, LSB first; the MSB step
// subtracts in signed mode so the result is exact two's complement.
module serial_mult_core
    import serial_multiply_test1_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              signed_mode,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    output logic [PROD_W-1:0] product_c,
    output logic              done_c,
    output logic              done,
    output logic              running
);

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(WIDTH - 1);

    state_e              state_q,   state_d;
    logic [PROD_W-1:0]   mcand_q,   mcand_d;
    logic [WIDTH-1:0]    mplier_q,  mplier_d;
    logic [PROD_W-1:0]   acc_q,     acc_d;
    logic [STEP_W-1:0]   step_q,    step_d;
    logic                signed_q,  signed_d;
    logic                done_q,    done_d;
    logic                running_q, running_d;
    logic [PROD_W-1:0]   addend;

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            step_q    <= '0;
            signed_q  <= 1'b0;
            done_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            step_q    <= step_d;
            signed_q  <= signed_d;
            done_q    <= done_d;
            running_q <= running_d;
        end
    end

    // Next-state and one shift-add step per BUSY cycle.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        step_d   = step_q;
        signed_d = signed_q;
        done_d   = 1'b0;
        done_c   = 1'b0;
        addend   = mcand_q << step_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mcand_d  = extend_operand(a, signed_mode);
                    mplier_d = b;
                    signed_d = signed_mode;
                    acc_d    = '0;
                    step_d   = '0;
                    state_d  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (mplier_q[step_q]) begin
                    // The multiplier MSB carries weight -2^(WIDTH-1) when signed.
                    if (signed_q && (step_q == LAST_STEP)) begin
                        acc_d = acc_q - addend;
                    end else begin
                        acc_d = acc_q + addend;
                    end
                end
                step_d = STEP_W'(step_q + 1'b1);
                if (step_q == LAST_STEP) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    done_c  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        running_d = (state_d == ST_BUSY);
        product_c = acc_d;
    end

    assign done    = done_q;
    assign running = running_q;

endmodule

// File: rtl/serial_multiply_test1.sv
// Serial multiply test block: three multiply modes sharing one shift-add core
// behind a start/running/done handshake, with per-mode result registers.
module serial_multiply_test1
    import serial_multiply_test1_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  a1,
    input  logic [WIDTH-1:0]  b1,
    input  logic [WIDTH-1:0]  a2,
    input  logic [WIDTH-1:0]  b2,
    input  logic [1:0]        seq,
    input  logic              start,
    output logic [PROD_W-1:0] out1,
    output logic [PROD_W-1:0] out2,
    output logic [OUT3_W-1:0] out3,
    output logic              running,
    output logic              done
);

    logic [1:0]        seq_q,  seq_d;
    logic [PROD_W-1:0] out1_q, out1_d;
    logic [PROD_W-1:0] out2_q, out2_d;
    logic [OUT3_W-1:0] out3_q, out3_d;

    logic              core_start_c;
    logic              core_signed_c;
    logic [WIDTH-1:0]  core_a_c;
    logic [WIDTH-1:0]  core_b_c;
    logic [PROD_W-1:0] core_product_c;
    logic              core_done_c;
    logic              core_done;
    logic              core_running;

    // Reserved mode and requests while busy never reach the core.
    assign core_start_c  = start && !core_running && (seq != MODE_RSVD);
    assign core_signed_c = (seq == MODE_SIGNED);
    assign core_a_c      = core_signed_c ? a2 : a1;
    assign core_b_c      = core_signed_c ? b2 : b1;

    serial_mult_core u_core (
        .clk         (clk),
        .reset       (reset),
        .start       (core_start_c),
        .signed_mode (core_signed_c),
        .a           (core_a_c),
        .b           (core_b_c),
        .product_c   (core_product_c),
        .done_c      (core_done_c),
        .done        (core_done),
        .running     (core_running)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seq_q  <= MODE_UNSIGNED;
            out1_q <= '0;
            out2_q <= '0;
            out3_q <= '0;
        end else begin
            seq_q  <= seq_d;
            out1_q <= out1_d;
            out2_q <= out2_d;
            out3_q <= out3_d;
        end
    end

    // Latch the mode on accept; route the finished product to its output only.
    always_comb begin
        seq_d  = seq_q;
        out1_d = out1_q;
        out2_d = out2_q;
        out3_d = out3_q;

        if (core_start_c) begin
            seq_d = seq;
        end

        if (core_done_c) begin
            case (seq_q)
                MODE_UNSIGNED: out1_d = core_product_c;
                MODE_SIGNED:   out2_d = core_product_c;
                MODE_TRUNC:    out3_d = core_product_c[PROD_W-1:TRUNC];
                default:       ;
            endcase
        end
    end

    assign out1    = out1_q;
    assign out2    = out2_q;
    assign out3    = out3_q;
    assign running = core_running;
    assign done    = core_done;

endmodule

// File: tb/tb_serial_multiply_test1.sv
// Self-checking bench for serial_multiply_test1: constant vector table, hand
// sequences for reset/handshake corners, exhaustive sweep and random runs.
module tb_serial_multiply_test1;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] a1, b1, a2, b2;
    logic [1:0] seq;
    logic       start;
    logic [7:0] out1, out2;
    logic [5:0] out3;
    logic       running, done;

    int checks   = 0;
    int failures = 0;

    // Reference result registers, computed with plain integer arithmetic.
    logic [7:0] m1, m2;
    logic [5:0] m3;

    always #5 clk = ~clk;

    serial_multiply_test1 dut (
        .clk     (clk),
        .reset   (reset),
        .a1      (a1),
        .b1      (b1),
        .a2      (a2),
        .b2      (b2),
        .seq     (seq),
        .start   (start),
        .out1    (out1),
        .out2    (out2),
        .out3    (out3),
        .running (running),
        .done    (done)
    );

    typedef struct {
        logic [1:0] s;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_outputs(input string name);
        chk({name, "_out1"}, int'(out1), int'(m1));
        chk({name, "_out2"}, int'(out2), int'(m2));
        chk({name, "_out3"}, int'(out3), int'(m3));
    endtask

    task automatic model_update(input logic [3:0] xa1, xb1, xa2, xb2, input logic [1:0] xs);
        int ua, ub, sa, sb;
        ua = int'(xa1);
        ub = int'(xb1);
        sa = (xa2 >= 4'd8) ? int'(xa2) - 16 : int'(xa2);
        sb = (xb2 >= 4'd8) ? int'(xb2) - 16 : int'(xb2);
        case (xs)
            2'd0: m1 = 8'(ua * ub);
            2'd1: m2 = 8'(sa * sb);
            2'd2: m3 = 6'((ua * ub) / 4);
            default: ;
        endcase
    endtask

    // One request. b2b: drive in the current cycle (used while done is high).
    // poke: raise start with different operands/mode mid-operation.
    task automatic do_op(input logic [3:0] xa1, xb1, xa2, xb2, input logic [1:0] xs,
                         input bit poke, input bit chk_after, input bit b2b);
        int lat;
        if (!b2b) @(negedge clk);
        a1 = xa1; b1 = xb1; a2 = xa2; b2 = xb2; seq = xs; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (xs == 2'd3) begin
            for (int i = 0; i < 6; i++) begin
                chk("rsvd_running", int'(running), 0);
                chk("rsvd_done", int'(done), 0);
                @(negedge clk);
            end
            chk_outputs("rsvd_hold");
            return;
        end
        chk("start_running", int'(running), 1);
        chk("start_done", int'(done), 0);
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                lat = i;
                break;
            end
            chk("busy_running", int'(running), 1);
            if (poke && i == 1) begin
                a1 = ~xa1; b1 = ~xb1; a2 = ~xa2; b2 = ~xb2;
                seq = (xs == 2'd0) ? 2'd1 : 2'd0;
                start = 1'b1;
            end
        end
        chk("latency", lat, 4);
        chk("done_running", int'(running), 0);
        model_update(xa1, xb1, xa2, xb2, xs);
        chk_outputs("result");
        if (chk_after) begin
            @(negedge clk);
            chk("done_pulse", int'(done), 0);
            chk("idle_running", int'(running), 0);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; seq = 2'd0;
        a1 = '0; b1 = '0; a2 = '0; b2 = '0;
        m1 = '0; m2 = '0; m3 = '0;

        vecs[0] = '{2'd1, 4'h8, 4'h8, 8'd64};
        vecs[1] = '{2'd1, 4'h8, 4'h7, 8'hC8};   // -56
        vecs[2] = '{2'd1, 4'hF, 4'hF, 8'd1};
        vecs[3] = '{2'd1, 4'h0, 4'h8, 8'd0};
        vecs[4] = '{2'd1, 4'h3, 4'hE, 8'hFA};   // 3 * -2 = -6
        vecs[5] = '{2'd0, 4'hF, 4'hF, 8'd225};
        vecs[6] = '{2'd2, 4'hF, 4'hF, 8'd56};
        vecs[7] = '{2'd0, 4'h0, 4'hF, 8'd0};
        vecs[8] = '{2'd2, 4'h3, 4'h1, 8'd0};

        repeat (2) @(negedge clk);
        chk("reset_out1", int'(out1), 0);
        chk("reset_out2", int'(out2), 0);
        chk("reset_out3", int'(out3), 0);
        chk("reset_running", int'(running), 0);
        chk("reset_done", int'(done), 0);
        reset = 1'b0;

        // Constant vector table.
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].s == 2'd1) do_op(4'h0, 4'h0, vecs[i].a, vecs[i].b, 2'd1, 0, 1, 0);
            else                   do_op(vecs[i].a, vecs[i].b, 4'h0, 4'h0, vecs[i].s, 0, 1, 0);
            case (vecs[i].s)
                2'd0:    chk($sformatf("vec%0d_out1", i), int'(out1), int'(vecs[i].exp));
                2'd1:    chk($sformatf("vec%0d_out2", i), int'(out2), int'(vecs[i].exp));
                default: chk($sformatf("vec%0d_out3", i), int'(out3), int'(vecs[i].exp));
            endcase
        end

        // Mode isolation and hold.
        do_op(4'd5, 4'd7, 4'h0, 4'h0, 2'd2, 0, 1, 0);
        do_op(4'd15, 4'd15, 4'h0, 4'h0, 2'd0, 0, 1, 0);
        do_op(4'h0, 4'h0, 4'd3, 4'hE, 2'd1, 0, 1, 0);
        chk("iso_out2", int'(out2), 8'hFA);
        chk("iso_out1", int'(out1), 225);
        chk("iso_out3", int'(out3), 8);

        // Ignored requests: reserved mode, and start while busy.
        do_op(4'd9, 4'd9, 4'd9, 4'd9, 2'd3, 0, 1, 0);
        do_op(4'd6, 4'd11, 4'd2, 4'd13, 2'd0, 1, 1, 0);
        do_op(4'd6, 4'd11, 4'd2, 4'd13, 2'd1, 1, 1, 0);
        do_op(4'd13, 4'd6, 4'd2, 4'd13, 2'd2, 1, 1, 0);

        // Back-to-back: next start issued in the cycle done is high.
        do_op(4'd12, 4'd10, 4'h0, 4'h0, 2'd0, 0, 0, 0);
        do_op(4'h0, 4'h0, 4'h9, 4'h5, 2'd1, 0, 0, 1);
        do_op(4'd11, 4'd14, 4'h0, 4'h0, 2'd2, 0, 1, 1);

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        a1 = 4'd7; b1 = 4'd7; seq = 2'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("arst_out1", int'(out1), 0);
        chk("arst_out2", int'(out2), 0);
        chk("arst_out3", int'(out3), 0);
        chk("arst_running", int'(running), 0);
        chk("arst_done", int'(done), 0);
        m1 = '0; m2 = '0; m3 = '0;
        @(negedge clk);
        reset = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("arst_no_done", int'(done), 0);
        end
        do_op(4'd3, 4'd5, 4'h0, 4'h0, 2'd0, 0, 1, 0);
        chk("arst_restart", int'(out1), 15);

        // Exhaustive sweep of all operand pairs in every mode.
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                for (int s = 0; s < 3; s++) begin
                    do_op(4'(x), 4'(y), 4'(x), 4'(y), 2'(s), 0, 0, 0);
                end
            end
        end

        // Random runs, including reserved mode and mid-operation pokes.
        for (int n = 0; n < 200; n++) begin
            do_op(4'($urandom_range(15)), 4'($urandom_range(15)),
                  4'($urandom_range(15)), 4'($urandom_range(15)),
                  2'($urandom_range(3)), 1'($urandom_range(1)), 1'($urandom_range(1)), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_multiply_test1.md
Name: serial_multiply_test1

Overview:
- Sequenced serial (shift-add, one operand bit per clock) multiplier test block. It hosts three multiply modes behind a single start/running/done handshake.
- seq selects the mode for each run:
  - unsigned 4x4 to 8-bit result (out1)
  - signed 4x4 to 8-bit result (out2)
  - unsigned 4x4 product truncated to its upper 6 bits (out3)
- Standalone verification block for the serial-multiply engine; no upstream/downstream protocol beyond the handshake.

Parameters:
- WIDTH, 4, operand width in bits (products are 2*WIDTH bits).
- TRUNC, 2, LSBs dropped for out3 (out3 width = 2*WIDTH-TRUNC).

Ports:
- clk  in  1  single clock, rising-edge active
- reset  in  1  asynchronous, active-high reset
- a1  in  4  unsigned operand A, mode 0 and mode 2
- b1  in  4  unsigned operand B, mode 0 and mode 2
- a2  in  4  signed (two's complement) operand A, mode 1
- b2  in  4  signed operand B, mode 1
- seq  in  2  mode select, sampled with start: 0=unsigned, 1=signed, 2=truncated unsigned, 3=reserved
- start  in  1  one-cycle request pulse
- out1  out  8  a1*b1, unsigned
- out2  out  8  a2*b2, signed two's complement
- out3  out  6  (a1*b1)>>2, i.e. bits [7:2] of the unsigned product
- running  out  1  high while an operation is in progress
- done  out  1  one-cycle pulse when a result is written

Behaviour:
- Reset (asynchronous, any time including mid-operation):
  - out1, out2, out3, running and done all go to 0.
  - Internal state returns to IDLE and any operation in progress is discarded.
- States: IDLE and BUSY.
- IDLE with start=1 and seq in {0,1,2}, at edge k:
  - Latch the selected operands and seq.
  - Clear the accumulator; step counter = 0.
  - Go to BUSY; running=1 from after edge k.
- seq=3 with start: ignored; stay IDLE; no done.
- start while BUSY: ignored; operands are not re-latched.
- BUSY runs one shift-add step per clock, over edges k+1..k+4 (WIDTH steps), examining one multiplier bit per step, LSB first.
- Signed mode:
  - Multiplicand is sign-extended to 8 bits.
  - The final step (multiplier MSB) subtracts the shifted multiplicand instead of adding.
  - Results are exact two's complement over the full range, e.g. -8*-8 = +64.
- At edge k+4:
  - Write the result to the output selected by the latched seq; the other two outputs hold their values.
  - running=0 and done=1 for exactly one cycle.
  - Return to IDLE.
- Latency: start sampled at edge k, result valid after edge k+4. running is high for exactly 4 cycles.
- A new start is accepted in the cycle done is high (back-to-back operation).
- Outputs are registered and hold until overwritten by the same mode or cleared by reset.
- Arithmetic:
  - Unsigned accumulator is 8 bits (no overflow possible; max 15*15 = 225).
  - out3 is taken from the full 8-bit product, not from a truncated accumulation.

Decomposition:
- Shared package contains:
  - WIDTH and TRUNC constants
  - seq mode encoding: MODE_UNSIGNED=0, MODE_SIGNED=1, MODE_TRUNC=2
  - FSM state enum
- One natural sub-module: serial_mult_core.
  - Interface: start, signed_mode, a, b in; product(8), done out.
  - The top instantiates it once, muxes operands by seq, and routes the product to out1/out2/out3.

Test Plan:
- Reset asserted mid-BUSY:
  - all outputs 0 immediately; running=0.
  - after release, IDLE; a new start works normally.
- Exhaustive sweep of a1,b1 over 0..15 with a2=a1, b2=b1 reinterpreted as signed; run seq 0, then 1, then 2, waiting for running=0 between runs:
  - out1 = a1*b1
  - out2 = signed product
  - out3 = out1[7:2]
  - all 256 pairs pass.
- Signed boundaries:
  - a2=-8, b2=-8 -> out2 = 64
  - a2=-8, b2=7 -> out2 = -56
  - a2=-1, b2=-1 -> out2 = 1
  - a2=0, b2=-8 -> out2 = 0
- Handshake timing: start pulse at edge k ->
  - running=1 after edges k..k+3
  - running=0 and done=1 after edge k+4
  - done=0 after edge k+5
- Mode isolation and hold: after seq=0 with 15*15 (out1=225), run seq=1 with 3*-2 -> out2=-6, out1 still 225, out3 unchanged.
- Ignored requests:
  - start mid-BUSY -> no re-latch, same completion time.
  - seq=3 start -> running stays 0, no done.
